byte_serializer: RTL
====================

# byte_serializer

Parallel-in/serial-out converter that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per accepted transfer, with a true/complement serial pair. It is the read-out end of the team's byte-wide D flip-flop register path: the capture register writes a byte, and this block consumes it and streams it onto a single-wire link. It supports back-to-back words with no idle bubble and stalls the serial stream under downstream backpressure.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- clk  input  1  single clock; all state updates on the rising edge.
- areset  input  1  asynchronous reset, active-high; clears all state immediately regardless of clk.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept din this cycle.
- sout  output  1  current serial bit.
- sout_n  output  1  always ~sout, including during reset.
- sout_valid  output  1  sout carries a payload bit.
- sout_last  output  1  current bit is the final bit of the word.
- sout_ready  input  1  downstream accepts the current bit this cycle.

## Operation
- Two states: IDLE (no word held) and SHIFT (word held, bits pending).
- A word transfer occurs on a rising edge where din_valid && din_ready; a bit transfer occurs on an edge where sout_valid && sout_ready.
- IDLE: din_ready=1, sout_valid=0, sout=0, sout_n=1, sout_last=0. On word transfer: load din into shift register, bit counter := 0, go to SHIFT.
- SHIFT: sout_valid=1; sout = MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of shift register; sout_last = (counter == WIDTH-1).
  - Bit transfer, not last: shift register shifts one position toward the output end (zero-filled); counter increments.
  - Bit transfer on last bit, din_valid=1: new word loads in the same edge, counter := 0, stay in SHIFT (zero-bubble).
  - Bit transfer on last bit, din_valid=0: go to IDLE.
  - sout_ready=0: shift register, counter, sout, sout_last all hold.
- din_ready = (state==IDLE) || (sout_last && sout_ready); combinational from state and sout_ready; forced 0 while areset is high.
- din is sampled only on the word-transfer edge; changes to din during SHIFT have no effect.
- Counter is $clog2(WIDTH) bits; it never exceeds WIDTH-1.

## Timing
- Reset (areset high, asynchronous): state=IDLE, shift register=0, counter=0; outputs sout=0, sout_n=1, sout_valid=0, sout_last=0, din_ready=0. Once areset falls, din_ready=1 combinationally; the first word can transfer on the first rising edge after deassertion.
- Latency: word transfer at edge N -> first bit valid in the cycle after edge N. With sout_ready held 1, bit k is presented in cycle N+1+k; sout_last in cycle N+WIDTH.
- Throughput: WIDTH bits per WIDTH cycles with continuous din_valid and sout_ready; no gap between words.
- Each stall cycle (sout_ready=0) extends the word by exactly one cycle.
- areset asserted mid-word: the in-flight word is discarded, with no partial completion and no sout_last. After release the block is in IDLE.
- din_valid while SHIFT and not (sout_last && sout_ready): din_ready=0; no transfer, and upstream must hold.

## Test plan
- Reset/idle: assert areset mid-cycle with no clock edge -> sout=0, sout_n=1, sout_valid=0, din_ready=0 immediately; release -> din_ready=1.
- Single word, MSB_FIRST=1: din=8'hA5, one valid pulse, sout_ready=1 -> sout 1,0,1,0,0,1,0,1 on cycles N+1..N+8; sout_last only on N+8; sout_n complementary throughout; IDLE at N+9.
- LSB-first: MSB_FIRST=0, din=8'h01 -> sout 1,0,0,0,0,0,0,0; sout_last on eighth bit.
- Back-to-back: din=8'hFF then 8'h00 with din_valid held -> 8 ones immediately followed by 8 zeros; din_ready pulses high only in the sout_last cycle; sout_valid never drops.
- Backpressure: din=8'hC3, sout_ready=0 for 3 cycles after bit 2 -> sout holds bit 2 value (0) for 4 cycles; the full sequence 1,1,0,0,0,0,1,1 completes at N+11; din_ready stays 0 throughout.
- Reset mid-word: areset asserted after bit 4 of 8'h5A -> outputs drop to reset values at once; after release, new din=8'h3C serializes cleanly as 0,0,1,1,1,1,0,0.

Source files
------------

// File: rtl/byte_serializer.sv
// byte_serializer: valid/ready parallel-in, serial-out shifter with true/complement output pair
module byte_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_n,
  output logic             sout_valid,
  output logic             sout_last,
  input  logic             sout_ready
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  // serial outputs decode straight from held state so stalls freeze them and reset clears them
  always_comb begin
    sout_valid = state == SHIFT;
    sout_last = sout_valid && cnt == CW'(WIDTH - 1);
    sout = sout_valid && (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
    sout_n = ~sout;
    din_ready = !areset && (!sout_valid || (sout_last && sout_ready));
  end
  // word load (including zero-bubble reload on the last bit) takes priority over bit shifting
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else if (din_valid && din_ready) begin
      state <= SHIFT;
      sr <= din;
      cnt <= '0;
    end else if (sout_valid && sout_ready) begin
      if (sout_last) state <= IDLE;
      else begin
        sr <= MSB_FIRST ? sr << 1 : sr >> 1;
        cnt <= cnt + 1'b1;
      end
    end
endmodule
